// File: rtl/credit_bank_control.sv
// credit_bank_control: per-target credit values with hit capture, per-frame commit, cooldown, optional all-lit bonus.
// Latency: number is 1 cycle after pixelCreditIndex; commit, scorePulse and bonusPulse land 1 cycle after startOfFrame.
// Backpressure: none; the block accepts every pixel and frame pulse, and its outputs are pulses and levels with no handshake.
//
// Ports:
//   clk, resetN           - clock, asynchronous active-low reset
//   startOfFrame          - one-cycle frame pulse; commits pending hits and steps the cooldowns
//   pixelOnCredit         - the scan is over some credit
//   pixelCreditIndex      - index of that credit; only meaningful while pixelOnCredit is high
//   collisionBallCredit   - the ball overlaps the credit at this pixel
//   number                - registered value of the credit under the scan (0 for an out-of-range index)
//   scorePulse/scoreCount - commit event and the number of targets committed (count holds between pulses)
//   bonusActive/blink     - bonus flash level and flash phase
//   bonusPulse            - one-cycle pulse when the bonus flash completes
// Build option: define CREDIT_BONUS_EN to include the all-lit bonus FSM; otherwise the bonus outputs are tied low.
module credit_bank_control #(
  parameter int NUM_CREDITS        = 4,
  parameter int MAX_VALUE          = 9,
  parameter int COOLDOWN_FRAMES    = 30,
  parameter int BONUS_FLASH_FRAMES = 64,
  parameter int IDX_W              = (NUM_CREDITS > 1) ? $clog2(NUM_CREDITS) : 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic             pixelOnCredit,
  input  logic [IDX_W-1:0] pixelCreditIndex,
  input  logic             collisionBallCredit,
  output logic [3:0]       number,
  output logic             scorePulse,
  output logic [IDX_W:0]   scoreCount,
  output logic             bonusActive,
  output logic             blink,
  output logic             bonusPulse
);

  localparam logic [3:0] MAX_V  = 4'(MAX_VALUE);
  localparam logic [7:0] COOL_V = 8'(COOLDOWN_FRAMES);

  logic [3:0]             value     [NUM_CREDITS];
  logic [3:0]             value_nxt [NUM_CREDITS];
  logic [7:0]             cool      [NUM_CREDITS];
  logic [7:0]             cool_nxt  [NUM_CREDITS];
  logic [NUM_CREDITS-1:0] pend;
  logic [NUM_CREDITS-1:0] pend_nxt;
  logic [NUM_CREDITS-1:0] commit;
  logic [IDX_W:0]         commit_cnt;
  logic [3:0]             number_nxt;
  logic                   hit;
  logic                   idle;
  logic                   in_clear;
  logic                   go_flash;

  // Frame-boundary step: commit pending targets, then age the rest.
  always_comb begin
    commit     = '0;
    commit_cnt = '0;
    number_nxt = '0;
    for (int i = 0; i < NUM_CREDITS; i++) begin
      commit[i]    = idle && startOfFrame && pend[i];
      value_nxt[i] = value[i];
      cool_nxt[i]  = cool[i];
      if (commit[i]) begin
        value_nxt[i] = (value[i] >= MAX_V) ? MAX_V : value[i] + 4'd1;
        cool_nxt[i]  = COOL_V;
      end else if (startOfFrame && (cool[i] != 8'd0)) begin
        cool_nxt[i] = cool[i] - 8'd1;
      end
      commit_cnt = commit_cnt + (IDX_W+1)'(commit[i]);
      // Indices at or beyond NUM_CREDITS never match, leaving number at 0.
      if (pixelCreditIndex == IDX_W'(i)) number_nxt = value[i];
    end
  end

  // Capture is judged against the post-commit state, so a hit coinciding
  // with startOfFrame lands in the new frame (and respects a freshly
  // loaded cooldown or a flash that is just starting).
  always_comb begin
    hit      = pixelOnCredit && collisionBallCredit;
    pend_nxt = pend;
    for (int i = 0; i < NUM_CREDITS; i++) begin
      if (commit[i] || !idle) pend_nxt[i] = 1'b0;
    end
    if (hit && idle && !go_flash) begin
      for (int i = 0; i < NUM_CREDITS; i++) begin
        if ((pixelCreditIndex == IDX_W'(i)) && (cool_nxt[i] == 8'd0)) pend_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_CREDITS; i++) begin
        value[i] <= '0;
        cool[i]  <= '0;
      end
      pend       <= '0;
      number     <= '0;
      scorePulse <= 1'b0;
      scoreCount <= '0;
    end else begin
      for (int i = 0; i < NUM_CREDITS; i++) begin
        value[i] <= in_clear ? 4'd0 : value_nxt[i];
        cool[i]  <= in_clear ? 8'd0 : cool_nxt[i];
      end
      pend       <= in_clear ? '0 : pend_nxt;
      number     <= number_nxt;
      scorePulse <= |commit;
      if (|commit) scoreCount <= commit_cnt;
    end
  end

`ifdef CREDIT_BONUS_EN
  typedef enum logic [1:0] {S_IDLE, S_FLASH, S_CLEAR} state_t;

  localparam logic [7:0] FLASH_V = 8'(BONUS_FLASH_FRAMES);

  state_t     state;
  logic [7:0] fcnt;
  logic       all_max;

  always_comb begin
    all_max = 1'b1;
    for (int i = 0; i < NUM_CREDITS; i++) begin
      if (value_nxt[i] != MAX_V) all_max = 1'b0;
    end
  end

  assign idle     = (state == S_IDLE);
  assign in_clear = (state == S_CLEAR);
  // Only a commit can complete the set, so the bonus starts on a commit frame.
  assign go_flash = idle && (|commit) && all_max;

  // bonusActive/blink follow the state one cycle late; bonusPulse is raised
  // on the edge that enters CLEAR so it coincides with the CLEAR cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= S_IDLE;
      fcnt        <= '0;
      bonusActive <= 1'b0;
      blink       <= 1'b0;
      bonusPulse  <= 1'b0;
    end else begin
      bonusPulse  <= 1'b0;
      bonusActive <= (state == S_FLASH);
      blink       <= (state == S_FLASH) && fcnt[3];
      case (state)
        S_IDLE: begin
          if (go_flash) begin
            state <= S_FLASH;
            fcnt  <= FLASH_V;
          end
        end
        S_FLASH: begin
          if (startOfFrame) begin
            fcnt <= fcnt - 8'd1;
            if (fcnt == 8'd1) begin
              state      <= S_CLEAR;
              bonusPulse <= 1'b1;
            end
          end
        end
        S_CLEAR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign idle        = 1'b1;
  assign in_clear    = 1'b0;
  assign go_flash    = 1'b0;
  assign bonusActive = 1'b0;
  assign blink       = 1'b0;
  assign bonusPulse  = 1'b0;
`endif

endmodule

// File: tb/tb_credit_bank_control.sv
// Bench for credit_bank_control: a frame-level reference model predicts every output for the
// next cycle; predictions are queued when stimulus is driven and compared after the clock edge.
module tb_credit_bank_control;

  localparam int NC    = 4;
  localparam int MAXV  = 2;
  localparam int COOL  = 3;
  localparam int FLASH = 16;
`ifdef CREDIT_BONUS_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       pixelOnCredit = 1'b0;
  logic [1:0] pixelCreditIndex = 2'd0;
  logic       collisionBallCredit = 1'b0;
  logic [3:0] number;
  logic       scorePulse;
  logic [2:0] scoreCount;
  logic       bonusActive;
  logic       blink;
  logic       bonusPulse;

  credit_bank_control #(
    .NUM_CREDITS(NC), .MAX_VALUE(MAXV), .COOLDOWN_FRAMES(COOL), .BONUS_FLASH_FRAMES(FLASH)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pixelOnCredit(pixelOnCredit),
    .pixelCreditIndex(pixelCreditIndex), .collisionBallCredit(collisionBallCredit),
    .number(number), .scorePulse(scorePulse), .scoreCount(scoreCount),
    .bonusActive(bonusActive), .blink(blink), .bonusPulse(bonusPulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int number;
    int sp;
    int sc;
    int ba;
    int bl;
    int bp;
  } exp_t;

  exp_t sbq[$];
  int   mv[NC];
  int   mc[NC];
  bit   mp[NC];
  int   m_state;  // 0 idle, 1 flash, 2 clear
  int   m_fcnt;
  int   m_sc;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      mv[i] = 0;
      mc[i] = 0;
      mp[i] = 1'b0;
    end
    m_state = 0;
    m_fcnt  = 0;
    m_sc    = 0;
  endtask

  // Advance the model by one clock and return the outputs expected after that edge.
  task automatic model_step(input bit sof, input bit on, input int idx, input bit col, output exp_t e);
    int cnt;
    bit was_idle;
    bit full;
    e.number = mv[idx];
    e.sp     = 0;
    e.bp     = 0;
    e.ba     = (m_state == 1) ? 1 : 0;
    e.bl     = ((m_state == 1) && m_fcnt[3]) ? 1 : 0;
    was_idle = (m_state == 0);
    cnt      = 0;
    case (m_state)
      0: begin
        if (sof) begin
          for (int i = 0; i < NC; i++) begin
            if (mp[i]) begin
              cnt++;
              mv[i] = (mv[i] + 1 > MAXV) ? MAXV : mv[i] + 1;
              mc[i] = COOL;
              mp[i] = 1'b0;
            end else if (mc[i] > 0) begin
              mc[i]--;
            end
          end
          if (cnt > 0) begin
            e.sp = 1;
            m_sc = cnt;
            full = 1'b1;
            for (int i = 0; i < NC; i++) if (mv[i] != MAXV) full = 1'b0;
            if (BONUS && full) begin
              m_state = 1;
              m_fcnt  = FLASH;
            end
          end
        end
      end
      1: begin
        for (int i = 0; i < NC; i++) mp[i] = 1'b0;
        if (sof) begin
          for (int i = 0; i < NC; i++) if (mc[i] > 0) mc[i]--;
          m_fcnt--;
          if (m_fcnt == 0) begin
            m_state = 2;
            e.bp    = 1;
          end
        end
      end
      default: begin
        for (int i = 0; i < NC; i++) begin
          mv[i] = 0;
          mc[i] = 0;
          mp[i] = 1'b0;
        end
        m_state = 0;
      end
    endcase
    e.sc = m_sc;
    if (was_idle && (m_state == 0) && on && col && (mc[idx] == 0)) mp[idx] = 1'b1;
  endtask

  // One clock: drive inputs, queue the prediction, then compare after the edge.
  task automatic cyc(input bit sof, input bit on, input logic [1:0] idx, input bit col);
    exp_t e;
    startOfFrame        = sof;
    pixelOnCredit       = on;
    pixelCreditIndex    = idx;
    collisionBallCredit = col;
    model_step(sof, on, int'(idx), col, e);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("number", int'(number), e.number);
    check("scorePulse", int'(scorePulse), e.sp);
    check("scoreCount", int'(scoreCount), e.sc);
    check("bonusActive", int'(bonusActive), e.ba);
    check("blink", int'(blink), e.bl);
    check("bonusPulse", int'(bonusPulse), e.bp);
  endtask

  // A frame scans the credits in turn; every fifth cycle the scan is off-credit
  // while the collision line is high, which must never register as a hit.
  task automatic frame(input bit [3:0] mask, input int len);
    for (int c = 0; c < len; c++) begin
      if (c % 5 == 4) cyc(1'b0, 1'b0, 2'($urandom_range(3, 0)), 1'b1);
      else            cyc(1'b0, 1'b1, 2'(c % 4), mask[c % 4]);
    end
    cyc(1'b1, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_number"}, int'(number), 0);
    check({tag, "_scorePulse"}, int'(scorePulse), 0);
    check({tag, "_scoreCount"}, int'(scoreCount), 0);
    check({tag, "_bonusActive"}, int'(bonusActive), 0);
    check({tag, "_blink"}, int'(blink), 0);
    check({tag, "_bonusPulse"}, int'(bonusPulse), 0);
  endtask

  initial begin
    model_reset();
    #1 resetN = 1'b0;
    #20;
    check_outputs_zero("reset");
    @(negedge clk);
    resetN = 1'b1;

    // Single target hit many times within one frame.
    frame(4'b0100, 250);
    frame(4'b0000, 12);
    for (int f = 0; f < 4; f++) frame(4'b0000, 8);

    // Continuous hits on credit 0 against the cooldown.
    for (int f = 0; f < 6; f++) frame(4'b0001, 20);
    for (int f = 0; f < 4; f++) frame(4'b0000, 8);

    // Several targets in one frame.
    frame(4'b1011, 20);
    frame(4'b0000, 20);
    for (int f = 0; f < 3; f++) frame(4'b0000, 8);

    // Saturation of credit 1, spaced past its cooldown.
    for (int r = 0; r < 4; r++) begin
      frame(4'b0010, 20);
      for (int f = 0; f < 3; f++) frame(4'b0000, 8);
    end

    // Back-to-back frame pulses.
    frame(4'b0100, 20);
    cyc(1'b1, 1'b0, 2'd2, 1'b0);
    cyc(1'b1, 1'b0, 2'd2, 1'b0);
    for (int f = 0; f < 4; f++) frame(4'b0000, 8);

    // Light every target; with the bonus built this flashes, ignores hits, then clears.
    for (int f = 0; f < 30; f++) frame(4'b1111, 16);
    frame(4'b0000, 12);

    // Reach the flash again and reset part-way through it.
    for (int f = 0; f < 12; f++) begin
      if (m_state == 1) break;
      frame(4'b1111, 16);
    end
    for (int f = 0; f < 4; f++) frame(4'b0000, 16);
    for (int c = 0; c < 5; c++) cyc(1'b0, 1'b1, 2'(c % 4), 1'b0);
    #2 resetN = 1'b0;
    #1;
    check_outputs_zero("midreset");
    model_reset();
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;

    // Fresh start after the abort: one hit gives value 1 and no bonus pulse appears.
    frame(4'b0100, 20);
    frame(4'b0000, 20);
    for (int f = 0; f < 3; f++) frame(4'b0000, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
